// File: rtl/config_pkg.sv
// Global configuration record shared across the core.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{XLEN: 32};

endpackage

// File: rtl/decode_pkg.sv
// Decoded micro-op as delivered by the issue queues.
package decode_pkg;

    typedef struct packed {
        logic        is_load;
        logic        is_store;
        logic [31:0] imm;
        logic [1:0]  lsu_size;
        logic        lsu_unsigned;
    } uop_t;

endpackage

// File: rtl/lsu_pkg.sv
// Load/store execution unit types and byte-enable helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        DC_REQ,
        DC_WAIT,
        WB
    } lsu_state_e;

    typedef enum logic [1:0] {
        LSU_B = 2'd0,
        LSU_H = 2'd1,
        LSU_W = 2'd2
    } lsu_size_e;

    function automatic logic [3:0] size_mask(input lsu_size_e size);
        case (size)
            LSU_B:   return 4'b0001;
            LSU_H:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for stores and extract/extend for loads; purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BE_W   = DATA_W / 8,
    parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
    input  lsu_size_e         size_i,
    input  logic              is_unsigned_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [DATA_W-1:0] ld_word_i,
    output logic [DATA_W-1:0] st_data_o,
    output logic [BE_W-1:0]   be_o,
    output logic [DATA_W-1:0] ld_result_o,
    output logic              misaligned_o
);

    logic [DATA_W-1:0] shifted;

    assign st_data_o = st_data_i << {offset_i, 3'b000};
    assign be_o      = BE_W'(size_mask(size_i)) << offset_i;
    assign shifted   = ld_word_i >> {offset_i, 3'b000};

    always_comb begin
        misaligned_o = 1'b0;
        ld_result_o  = shifted;
        case (size_i)
            LSU_B: begin
                ld_result_o = {{(DATA_W-8){shifted[7] & ~is_unsigned_i}}, shifted[7:0]};
            end
            LSU_H: begin
                misaligned_o = offset_i[0];
                ld_result_o  = {{(DATA_W-16){shifted[15] & ~is_unsigned_i}}, shifted[15:0]};
            end
            default: begin
                misaligned_o = (offset_i != '0);
            end
        endcase
    end

endmodule

// File: rtl/lsu_exec_unit.sv
// Single-issue load/store execute stage: address generation, store-buffer fill,
// store-to-load forwarding, D-cache access and CDB writeback.
module lsu_exec_unit
    import lsu_pkg::*;
#(
    parameter config_pkg::cfg_t Cfg    = config_pkg::EmptyCfg,
    parameter int unsigned      DATA_W = Cfg.XLEN,
    parameter int unsigned      TAG_W  = 6,
    parameter int unsigned      SB_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 lsu_en_i,
    input  decode_pkg::uop_t     lsu_uop_i,
    input  logic [DATA_W-1:0]    lsu_v1_i,
    input  logic [DATA_W-1:0]    lsu_v2_i,
    input  logic [TAG_W-1:0]     lsu_dst_i,
    input  logic [SB_W-1:0]      lsu_sb_id_i,
    output logic                 fu_ready_o,
    output logic                 sb_wr_en_o,
    output logic [SB_W-1:0]      sb_wr_id_o,
    output logic [DATA_W-1:0]    sb_wr_addr_o,
    output logic [DATA_W-1:0]    sb_wr_data_o,
    output logic [DATA_W/8-1:0]  sb_wr_be_o,
    output logic [DATA_W-1:0]    sb_q_addr_o,
    input  logic                 sb_q_hit_i,
    input  logic [DATA_W-1:0]    sb_q_data_i,
    input  logic                 sb_q_stall_i,
    output logic                 dc_req_valid_o,
    input  logic                 dc_req_ready_i,
    output logic [DATA_W-1:0]    dc_req_addr_o,
    input  logic                 dc_rsp_valid_i,
    input  logic [DATA_W-1:0]    dc_rsp_data_i,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [TAG_W-1:0]     wb_tag_o,
    output logic [DATA_W-1:0]    wb_data_o,
    output logic                 wb_exc_o
);

    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    lsu_state_e        state_q;
    decode_pkg::uop_t  uop_q;
    logic [DATA_W-1:0] v1_q;
    logic [DATA_W-1:0] v2_q;
    logic [TAG_W-1:0]  dst_q;
    logic [SB_W-1:0]   sb_id_q;
    logic              drop_pending_q;

    logic [DATA_W-1:0]   addr;
    logic [DATA_W-1:0]   addr_aligned;
    logic [DATA_W-1:0]   st_data;
    logic [DATA_W/8-1:0] st_be;
    logic [DATA_W-1:0]   ld_word;
    logic [DATA_W-1:0]   ld_result;
    logic                misaligned;

    // Operand registers stay live until WB, so the address is recomputed rather than stored.
    assign addr         = v1_q + DATA_W'(signed'(uop_q.imm));
    assign addr_aligned = {addr[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
    assign sb_q_addr_o  = addr;
    assign ld_word      = (state_q == EXEC) ? sb_q_data_i : dc_rsp_data_i;
    assign fu_ready_o   = (state_q == IDLE) && !drop_pending_q;

    lsu_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .size_i        (lsu_size_e'(uop_q.lsu_size)),
        .is_unsigned_i (uop_q.lsu_unsigned),
        .offset_i      (addr[OFF_W-1:0]),
        .st_data_i     (v2_q),
        .ld_word_i     (ld_word),
        .st_data_o     (st_data),
        .be_o          (st_be),
        .ld_result_o   (ld_result),
        .misaligned_o  (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            uop_q          <= '0;
            v1_q           <= '0;
            v2_q           <= '0;
            dst_q          <= '0;
            sb_id_q        <= '0;
            drop_pending_q <= 1'b0;
            sb_wr_en_o     <= 1'b0;
            sb_wr_id_o     <= '0;
            sb_wr_addr_o   <= '0;
            sb_wr_data_o   <= '0;
            sb_wr_be_o     <= '0;
            dc_req_valid_o <= 1'b0;
            dc_req_addr_o  <= '0;
            wb_valid_o     <= 1'b0;
            wb_tag_o       <= '0;
            wb_data_o      <= '0;
            wb_exc_o       <= 1'b0;
        end else begin
            sb_wr_en_o <= 1'b0;
            if (flush_i) begin
                state_q        <= IDLE;
                dc_req_valid_o <= 1'b0;
                wb_valid_o     <= 1'b0;
                // A request already accepted by the cache will still answer; swallow it.
                if ((state_q == DC_WAIT && !dc_rsp_valid_i) ||
                    (state_q == DC_REQ && dc_req_ready_i)) begin
                    drop_pending_q <= 1'b1;
                end else if (drop_pending_q && dc_rsp_valid_i) begin
                    drop_pending_q <= 1'b0;
                end
            end else begin
                if (drop_pending_q && dc_rsp_valid_i) begin
                    drop_pending_q <= 1'b0;
                end
                case (state_q)
                    IDLE: begin
                        if (lsu_en_i && fu_ready_o) begin
                            uop_q   <= lsu_uop_i;
                            v1_q    <= lsu_v1_i;
                            v2_q    <= lsu_v2_i;
                            dst_q   <= lsu_dst_i;
                            sb_id_q <= lsu_sb_id_i;
                            state_q <= EXEC;
                        end
                    end
                    EXEC: begin
                        if (misaligned) begin
                            wb_valid_o <= 1'b1;
                            wb_tag_o   <= dst_q;
                            wb_data_o  <= '0;
                            wb_exc_o   <= 1'b1;
                            state_q    <= WB;
                        end else if (uop_q.is_store) begin
                            sb_wr_en_o   <= 1'b1;
                            sb_wr_id_o   <= sb_id_q;
                            sb_wr_addr_o <= addr_aligned;
                            sb_wr_data_o <= st_data;
                            sb_wr_be_o   <= st_be;
                            wb_valid_o   <= 1'b1;
                            wb_tag_o     <= dst_q;
                            wb_data_o    <= '0;
                            wb_exc_o     <= 1'b0;
                            state_q      <= WB;
                        end else if (uop_q.is_load) begin
                            if (sb_q_stall_i) begin
                                state_q <= EXEC;
                            end else if (sb_q_hit_i) begin
                                wb_valid_o <= 1'b1;
                                wb_tag_o   <= dst_q;
                                wb_data_o  <= ld_result;
                                wb_exc_o   <= 1'b0;
                                state_q    <= WB;
                            end else begin
                                dc_req_valid_o <= 1'b1;
                                dc_req_addr_o  <= addr_aligned;
                                state_q        <= DC_REQ;
                            end
                        end else begin
                            wb_valid_o <= 1'b1;
                            wb_tag_o   <= dst_q;
                            wb_data_o  <= '0;
                            wb_exc_o   <= 1'b0;
                            state_q    <= WB;
                        end
                    end
                    DC_REQ: begin
                        if (dc_req_ready_i) begin
                            dc_req_valid_o <= 1'b0;
                            state_q        <= DC_WAIT;
                        end
                    end
                    DC_WAIT: begin
                        if (dc_rsp_valid_i) begin
                            wb_valid_o <= 1'b1;
                            wb_tag_o   <= dst_q;
                            wb_data_o  <= ld_result;
                            wb_exc_o   <= 1'b0;
                            state_q    <= WB;
                        end
                    end
                    WB: begin
                        if (wb_ready_i) begin
                            wb_valid_o <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsu_exec_unit.sv
// Directed stimulus with queue-based scoreboards for writeback, store-buffer and D-cache traffic.
module tb_lsu_exec_unit;
    import lsu_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             lsu_en = 1'b0;
    decode_pkg::uop_t uop = '0;
    logic [31:0]      v1 = '0;
    logic [31:0]      v2 = '0;
    logic [5:0]       dst = '0;
    logic [3:0]       sb_id = '0;
    logic             fu_ready_o;
    logic             sb_wr_en_o;
    logic [3:0]       sb_wr_id_o;
    logic [31:0]      sb_wr_addr_o;
    logic [31:0]      sb_wr_data_o;
    logic [3:0]       sb_wr_be_o;
    logic [31:0]      sb_q_addr_o;
    logic             sb_q_hit = 1'b0;
    logic [31:0]      sb_q_data = '0;
    logic             sb_q_stall = 1'b0;
    logic             dc_req_valid_o;
    logic             dc_req_ready = 1'b0;
    logic [31:0]      dc_req_addr_o;
    logic             dc_rsp_valid = 1'b0;
    logic [31:0]      dc_rsp_data = '0;
    logic             wb_valid_o;
    logic             wb_ready = 1'b1;
    logic [5:0]       wb_tag_o;
    logic [31:0]      wb_data_o;
    logic             wb_exc_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
        logic        exc;
    } wb_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } sbw_t;

    wb_t         wb_q[$];
    sbw_t        sb_q[$];
    logic [31:0] dc_q[$];

    always #5 clk = ~clk;

    lsu_exec_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush),
        .lsu_en_i       (lsu_en),
        .lsu_uop_i      (uop),
        .lsu_v1_i       (v1),
        .lsu_v2_i       (v2),
        .lsu_dst_i      (dst),
        .lsu_sb_id_i    (sb_id),
        .fu_ready_o     (fu_ready_o),
        .sb_wr_en_o     (sb_wr_en_o),
        .sb_wr_id_o     (sb_wr_id_o),
        .sb_wr_addr_o   (sb_wr_addr_o),
        .sb_wr_data_o   (sb_wr_data_o),
        .sb_wr_be_o     (sb_wr_be_o),
        .sb_q_addr_o    (sb_q_addr_o),
        .sb_q_hit_i     (sb_q_hit),
        .sb_q_data_i    (sb_q_data),
        .sb_q_stall_i   (sb_q_stall),
        .dc_req_valid_o (dc_req_valid_o),
        .dc_req_ready_i (dc_req_ready),
        .dc_req_addr_o  (dc_req_addr_o),
        .dc_rsp_valid_i (dc_rsp_valid),
        .dc_rsp_data_i  (dc_rsp_data),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready),
        .wb_tag_o       (wb_tag_o),
        .wb_data_o      (wb_data_o),
        .wb_exc_o       (wb_exc_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every cycle an output is valid it must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_valid_o) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 32'(wb_valid_o), 32'd0);
                end else begin
                    chk("wb_tag", 32'(wb_tag_o), 32'(wb_q[0].tag));
                    chk("wb_data", wb_data_o, wb_q[0].data);
                    chk("wb_exc", 32'(wb_exc_o), 32'(wb_q[0].exc));
                    if (wb_ready) void'(wb_q.pop_front());
                end
            end
            if (sb_wr_en_o) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", 32'(sb_wr_en_o), 32'd0);
                end else begin
                    chk("sb_id", 32'(sb_wr_id_o), 32'(sb_q[0].id));
                    chk("sb_addr", sb_wr_addr_o, sb_q[0].addr);
                    chk("sb_data", sb_wr_data_o, sb_q[0].data);
                    chk("sb_be", 32'(sb_wr_be_o), 32'(sb_q[0].be));
                    void'(sb_q.pop_front());
                end
            end
            if (dc_req_valid_o) begin
                if (dc_q.size() == 0) begin
                    chk("dc_unexpected", 32'(dc_req_valid_o), 32'd0);
                end else begin
                    chk("dc_addr", dc_req_addr_o, dc_q[0]);
                    if (dc_req_ready) void'(dc_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] imm,
                         input logic [31:0] d, input logic [5:0] tag, input logic [3:0] id);
        int n = 0;
        while (!fu_ready_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!fu_ready_o) chk("issue_ready_timeout", 32'(fu_ready_o), 32'd1);
        uop.is_load      = ld;
        uop.is_store     = st;
        uop.lsu_size     = sz;
        uop.lsu_unsigned = uns;
        uop.imm          = imm;
        v1               = a;
        v2               = d;
        dst              = tag;
        sb_id            = id;
        lsu_en           = 1'b1;
        @(posedge clk);
        #1;
        lsu_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(fu_ready_o && wb_q.size() == 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: fu_ready=%0b pending_wb=%0d expected idle", fu_ready_o,
                     wb_q.size());
        end
    endtask

    task automatic wait_dc_req();
        int n = 0;
        while (!dc_req_valid_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!dc_req_valid_o) chk("dc_req_timeout", 32'(dc_req_valid_o), 32'd1);
    endtask

    task automatic dc_serve(input int rdy_dly, input int rsp_dly, input logic [31:0] data);
        wait_dc_req();
        repeat (rdy_dly) begin
            @(posedge clk);
            #1;
        end
        dc_req_ready = 1'b1;
        @(posedge clk);
        #1;
        dc_req_ready = 1'b0;
        repeat (rsp_dly) begin
            @(posedge clk);
            #1;
        end
        dc_rsp_valid = 1'b1;
        dc_rsp_data  = data;
        @(posedge clk);
        #1;
        dc_rsp_valid = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_fu_ready", 32'(fu_ready_o), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_sb_wr_en", 32'(sb_wr_en_o), 32'd0);
        chk("rst_dc_req_valid", 32'(dc_req_valid_o), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Store word with latency and single-cycle strobe checks
        sb_q.push_back('{id: 4'd3, addr: 32'h1004, data: 32'hDEADBEEF, be: 4'hF});
        wb_q.push_back('{tag: 6'd5, data: 32'h0, exc: 1'b0});
        issue(1'b0, 1'b1, LSU_W, 1'b0, 32'h1000, 32'd4, 32'hDEADBEEF, 6'd5, 4'd3);
        chk("st_exec_no_wb", 32'(wb_valid_o), 32'd0);
        chk("st_busy", 32'(fu_ready_o), 32'd0);
        @(posedge clk);
        #1;
        chk("st_wb_latency", 32'(wb_valid_o), 32'd1);
        chk("st_sb_pulse", 32'(sb_wr_en_o), 32'd1);
        @(posedge clk);
        #1;
        chk("st_sb_pulse_end", 32'(sb_wr_en_o), 32'd0);
        wait_idle();

        // Half store with negative immediate, byte store at top lane
        sb_q.push_back('{id: 4'd4, addr: 32'h1FFC, data: 32'hABCD0000, be: 4'hC});
        wb_q.push_back('{tag: 6'd6, data: 32'h0, exc: 1'b0});
        issue(1'b0, 1'b1, LSU_H, 1'b0, 32'h2000, 32'hFFFFFFFE, 32'h0000ABCD, 6'd6, 4'd4);
        wait_idle();
        sb_q.push_back('{id: 4'd5, addr: 32'h3000, data: 32'h11000000, be: 4'h8});
        wb_q.push_back('{tag: 6'd7, data: 32'h0, exc: 1'b0});
        issue(1'b0, 1'b1, LSU_B, 1'b0, 32'h3003, 32'd0, 32'h12345611, 6'd7, 4'd5);
        wait_idle();

        // Signed and unsigned byte loads through the D-cache
        dc_q.push_back(32'h1000);
        wb_q.push_back('{tag: 6'd8, data: 32'hFFFFFF80, exc: 1'b0});
        issue(1'b1, 1'b0, LSU_B, 1'b0, 32'h1000, 32'd3, 32'h0, 6'd8, 4'd0);
        dc_serve(0, 1, 32'h80FF0000);
        wait_idle();
        dc_q.push_back(32'h1000);
        wb_q.push_back('{tag: 6'd9, data: 32'h00000080, exc: 1'b0});
        issue(1'b1, 1'b0, LSU_B, 1'b1, 32'h1000, 32'd3, 32'h0, 6'd9, 4'd0);
        dc_serve(0, 0, 32'h80FF0000);
        wait_idle();

        // Misaligned half load and misaligned word store: exception, no side traffic
        wb_q.push_back('{tag: 6'd10, data: 32'h0, exc: 1'b1});
        issue(1'b1, 1'b0, LSU_H, 1'b0, 32'h1000, 32'd1, 32'h0, 6'd10, 4'd0);
        wait_idle();
        wb_q.push_back('{tag: 6'd11, data: 32'h0, exc: 1'b1});
        issue(1'b0, 1'b1, LSU_W, 1'b0, 32'h1000, 32'd2, 32'hFFFFFFFF, 6'd11, 4'd1);
        wait_idle();

        // Forwarding stall for three cycles, then a hit
        sb_q_stall = 1'b1;
        issue(1'b1, 1'b0, LSU_H, 1'b1, 32'h2000, 32'd2, 32'h0, 6'd12, 4'd0);
        chk("fwd_query_addr", sb_q_addr_o, 32'h2002);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("stall_no_wb", 32'(wb_valid_o), 32'd0);
        chk("stall_no_dc", 32'(dc_req_valid_o), 32'd0);
        chk("stall_busy", 32'(fu_ready_o), 32'd0);
        wb_q.push_back('{tag: 6'd12, data: 32'h00001234, exc: 1'b0});
        sb_q_stall = 1'b0;
        sb_q_hit   = 1'b1;
        sb_q_data  = 32'h12345678;
        @(posedge clk);
        #1;
        sb_q_hit = 1'b0;
        wait_idle();

        // Signed half forwarded directly
        wb_q.push_back('{tag: 6'd13, data: 32'hFFFF8001, exc: 1'b0});
        sb_q_hit  = 1'b1;
        sb_q_data = 32'h80015678;
        issue(1'b1, 1'b0, LSU_H, 1'b0, 32'h2000, 32'd2, 32'h0, 6'd13, 4'd0);
        @(posedge clk);
        #1;
        sb_q_hit = 1'b0;
        wait_idle();

        // Word load with a back-pressured cache request
        dc_q.push_back(32'h4000);
        wb_q.push_back('{tag: 6'd14, data: 32'hCAFEF00D, exc: 1'b0});
        issue(1'b1, 1'b0, LSU_W, 1'b0, 32'h3FF0, 32'h10, 32'h0, 6'd14, 4'd0);
        dc_serve(4, 2, 32'hCAFEF00D);
        wait_idle();

        // Flush while waiting for the cache: response must be swallowed
        dc_q.push_back(32'h5008);
        issue(1'b1, 1'b0, LSU_W, 1'b0, 32'h5000, 32'd8, 32'h0, 6'd20, 4'd0);
        wait_dc_req();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        dc_req_ready = 1'b1;
        @(posedge clk);
        #1;
        dc_req_ready = 1'b0;
        chk("flush_dc_req_dropped", 32'(dc_req_valid_o), 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush  = 1'b0;
        lsu_en = 1'b1;
        chk("drop_busy_0", 32'(fu_ready_o), 32'd0);
        chk("drop_no_wb", 32'(wb_valid_o), 32'd0);
        @(posedge clk);
        #1;
        chk("drop_busy_1", 32'(fu_ready_o), 32'd0);
        dc_rsp_valid = 1'b1;
        dc_rsp_data  = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        dc_rsp_valid = 1'b0;
        lsu_en       = 1'b0;
        chk("drop_released", 32'(fu_ready_o), 32'd1);
        @(posedge clk);
        #1;
        chk("drop_no_accept", 32'(fu_ready_o), 32'd1);

        // Writeback back-pressure
        wb_ready = 1'b0;
        sb_q.push_back('{id: 4'd6, addr: 32'h6000, data: 32'h000000A5, be: 4'h1});
        wb_q.push_back('{tag: 6'd15, data: 32'h0, exc: 1'b0});
        issue(1'b0, 1'b1, LSU_B, 1'b0, 32'h6000, 32'd0, 32'h000000A5, 6'd15, 4'd6);
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("wb_hold_busy", 32'(fu_ready_o), 32'd0);
        end
        wb_ready = 1'b1;
        wait_idle();

        // Asynchronous reset in the middle of a writeback
        wb_ready  = 1'b0;
        sb_q_hit  = 1'b1;
        sb_q_data = 32'h55AA55AA;
        wb_q.push_back('{tag: 6'd9, data: 32'h55AA55AA, exc: 1'b0});
        issue(1'b1, 1'b0, LSU_W, 1'b0, 32'h7000, 32'd0, 32'h0, 6'd9, 4'd0);
        @(posedge clk);
        #1;
        sb_q_hit = 1'b0;
        chk("pre_rst_wb_valid", 32'(wb_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_mid_wb_tag", 32'(wb_tag_o), 32'd0);
        chk("rst_mid_wb_data", wb_data_o, 32'd0);
        chk("rst_mid_fu_ready", 32'(fu_ready_o), 32'd1);
        wb_q.delete();
        #4 rst_n = 1'b1;
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_fu_ready", 32'(fu_ready_o), 32'd1);
        chk("post_rst_wb_valid", 32'(wb_valid_o), 32'd0);

        chk("end_wb_q_empty", 32'(wb_q.size()), 32'd0);
        chk("end_sb_q_empty", 32'(sb_q.size()), 32'd0);
        chk("end_dc_q_empty", 32'(dc_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
